// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline.
// Resolves load-use, branch, multi-cycle execute and data-memory wait hazards.
module pipe_ctrl #(
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                   id_rs1_re_i,
  input  logic                   id_rs2_re_i,
  input  logic [RADDR_WIDTH-1:0] exe_reg_waddr_i,
  input  logic                   exe_is_load_i,
  input  logic                   exe_branch_i,
  input  logic                   exe_busy_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ack_i,
  output logic [4:0]             stall_o,
  output logic [4:0]             flush_o,
  output logic                   timeout_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ABORT    = 2'd2;

  localparam logic [WCW-1:0]       WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0]       WAIT_ONE  = WCW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  // Stage masks, bit order: pc, if_id, id_exe, exe_mem, mem_wb
  localparam logic [4:0] STALL_MEM  = 5'h0F;
  localparam logic [4:0] FLUSH_MEM  = 5'h10;
  localparam logic [4:0] STALL_BUSY = 5'h07;
  localparam logic [4:0] FLUSH_BUSY = 5'h08;
  localparam logic [4:0] FLUSH_BR   = 5'h06;
  localparam logic [4:0] STALL_LU   = 5'h03;
  localparam logic [4:0] FLUSH_LU   = 5'h04;
  localparam logic [4:0] FLUSH_ABRT = 5'h18;
  localparam logic [4:0] FLUSH_ALL  = 5'h1F;

  logic [1:0]           state_q, state_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic rs1_hit_c, rs2_hit_c, load_use_c, mem_wait_c;

  // Hazard detection
  always_comb begin
    rs1_hit_c  = id_rs1_re_i && (id_rs1_addr_i == exe_reg_waddr_i);
    rs2_hit_c  = id_rs2_re_i && (id_rs2_addr_i == exe_reg_waddr_i);
    load_use_c = exe_is_load_i && (exe_reg_waddr_i != '0) && (rs1_hit_c || rs2_hit_c);
    mem_wait_c = 1'b0;
    case (state_q)
      ST_RUN:      mem_wait_c = mem_req_i && !mem_ack_i;
      ST_MEM_WAIT: mem_wait_c = !mem_ack_i;
      default:     mem_wait_c = 1'b0;
    endcase
  end

  // Prioritised stall/flush decision, zero latency
  always_comb begin
    stall_o = 5'h00;
    flush_o = 5'h00;
    if (!rst_i) begin
      flush_o = FLUSH_ALL;
    end else if (state_q == ST_ABORT) begin
      flush_o = FLUSH_ABRT;
    end else if (mem_wait_c) begin
      stall_o = STALL_MEM;
      flush_o = FLUSH_MEM;
    end else if (exe_busy_i) begin
      stall_o = STALL_BUSY;
      flush_o = FLUSH_BUSY;
    end else if (exe_branch_i) begin
      flush_o = FLUSH_BR;
    end else if (load_use_c) begin
      stall_o = STALL_LU;
      flush_o = FLUSH_LU;
    end
  end

  // Memory wait / timeout FSM
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_ABORT;
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_ABORT: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating stall-cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|stall_o) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors with literal expectations, plus an
// access-length model compared against the DUT every cycle.
module tb_pipe_ctrl;

  localparam int unsigned RW   = 5;
  localparam int unsigned TOUT = 4;
  localparam int unsigned CW   = 6;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [RW-1:0] id_rs1_addr_i, id_rs2_addr_i, exe_reg_waddr_i;
  logic          id_rs1_re_i, id_rs2_re_i;
  logic          exe_is_load_i, exe_branch_i, exe_busy_i;
  logic          mem_req_i, mem_ack_i;
  logic [4:0]    stall_o, flush_o;
  logic          timeout_o;
  logic [CW-1:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit rst_v    = 1'b0;

  pipe_ctrl #(.RADDR_WIDTH(RW), .TIMEOUT(TOUT), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .exe_reg_waddr_i(exe_reg_waddr_i), .exe_is_load_i(exe_is_load_i),
    .exe_branch_i(exe_branch_i), .exe_busy_i(exe_busy_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .flush_o(flush_o),
    .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: tracks how many cycles the current memory access has stalled
  initial begin
    int  m_stalled;
    bit  m_abort, m_tout, lu, mw;
    int  m_cnt;
    logic [4:0] es, ef;
    m_stalled = 0; m_abort = 0; m_tout = 0; m_cnt = 0;
    forever begin
      @(negedge clk_i);
      lu = exe_is_load_i && (exe_reg_waddr_i != 0) &&
           ((id_rs1_re_i && id_rs1_addr_i == exe_reg_waddr_i) ||
            (id_rs2_re_i && id_rs2_addr_i == exe_reg_waddr_i));
      mw = (m_stalled == 0) ? (mem_req_i && !mem_ack_i) : !mem_ack_i;
      es = 5'h00; ef = 5'h00;
      if (!rst_i)            ef = 5'h1F;
      else if (m_abort)      ef = 5'h18;
      else if (mw)           begin es = 5'h0F; ef = 5'h10; end
      else if (exe_busy_i)   begin es = 5'h07; ef = 5'h08; end
      else if (exe_branch_i) ef = 5'h06;
      else if (lu)           begin es = 5'h03; ef = 5'h04; end
      check("model.stall", 32'(stall_o), 32'(es));
      check("model.flush", 32'(flush_o), 32'(ef));
      check("model.timeout", 32'(timeout_o), 32'(m_tout));
      check("model.stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
      if (!rst_i) begin
        m_stalled = 0; m_abort = 0; m_tout = 0; m_cnt = 0;
      end else begin
        m_tout = 0;
        if (m_abort) begin
          m_abort = 0; m_stalled = 0;
        end else if (mw) begin
          m_stalled++;
          if (m_stalled == TOUT) begin
            m_abort = 1; m_stalled = 0; m_tout = 1;
          end
        end else begin
          m_stalled = 0;
        end
        if (es != 0 && m_cnt < CMAX) m_cnt++;
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge
  task automatic drv(input int r1, input int r2, input bit e1, input bit e2, input int wa,
                     input bit ld, input bit br, input bit bz, input bit rq, input bit ak);
    @(posedge clk_i); #1;
    rst_i = rst_v;
    id_rs1_addr_i = RW'(r1); id_rs2_addr_i = RW'(r2);
    id_rs1_re_i = e1; id_rs2_re_i = e2; exe_reg_waddr_i = RW'(wa);
    exe_is_load_i = ld; exe_branch_i = br; exe_busy_i = bz;
    mem_req_i = rq; mem_ack_i = ak;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lit(input string nm, input logic [4:0] es, input logic [4:0] ef);
    check({nm, ".stall"}, 32'(stall_o), 32'(es));
    check({nm, ".flush"}, 32'(flush_o), 32'(ef));
  endtask

  initial begin
    rst_i = 1'b0;
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; exe_reg_waddr_i = '0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; exe_is_load_i = 0;
    exe_branch_i = 0; exe_busy_i = 0; mem_req_i = 0; mem_ack_i = 0;
    repeat (2) @(posedge clk_i);
    #2;
    lit("reset", 5'h00, 5'h1F);
    check("reset.cnt", 32'(stall_cnt_o), 0);
    check("reset.timeout", 32'(timeout_o), 0);

    rst_v = 1'b1;
    idle();                                   lit("idle", 5'h00, 5'h00);
    drv(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);        lit("lu_rs1", 5'h03, 5'h04);
    drv(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);        lit("lu_x0", 5'h00, 5'h00);
    drv(1, 7, 1, 1, 7, 1, 0, 0, 0, 0);        lit("lu_rs2", 5'h03, 5'h04);
    drv(1, 7, 1, 0, 7, 1, 0, 0, 0, 0);        lit("lu_rs2_nore", 5'h00, 5'h00);
    drv(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);        lit("branch_lu", 5'h00, 5'h06);

    // Memory wait of three cycles then ack
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);      lit("memwait", 5'h0F, 5'h10);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);        lit("mem_ack", 5'h00, 5'h00);
    check("mem_ack.cnt", 32'(stall_cnt_o), 5);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);        lit("mem_first_ack", 5'h00, 5'h00);
    idle();                                   lit("after_first_ack", 5'h00, 5'h00);
    check("first_ack.cnt", 32'(stall_cnt_o), 5);

    // Timeout: exactly four stall cycles, then abort
    for (int i = 0; i < TOUT; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);      lit("tout_wait", 5'h0F, 5'h10);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);        lit("abort", 5'h00, 5'h18);
    check("abort.timeout", 32'(timeout_o), 1);
    check("abort.cnt", 32'(stall_cnt_o), 9);
    idle();                                   lit("post_abort", 5'h00, 5'h00);
    check("post_abort.timeout", 32'(timeout_o), 0);

    // Ack on the last permitted cycle wins over the timeout
    for (int i = 0; i < TOUT - 1; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);      lit("late_wait", 5'h0F, 5'h10);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);        lit("late_ack", 5'h00, 5'h00);
    idle();                                   lit("post_late", 5'h00, 5'h00);
    check("post_late.timeout", 32'(timeout_o), 0);
    check("post_late.cnt", 32'(stall_cnt_o), 12);

    // Priority between memory wait, busy and branch
    drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);        lit("prio_mem", 5'h0F, 5'h10);
    drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);        lit("prio_busy_ack", 5'h07, 5'h08);
    drv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);        lit("prio_busy", 5'h07, 5'h08);
    idle();
    check("prio.cnt", 32'(stall_cnt_o), 15);

    // Reset in the middle of a memory wait
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);        lit("pre_rst_wait", 5'h0F, 5'h10);
    rst_v = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);        lit("mid_rst", 5'h00, 5'h1F);
    rst_v = 1'b1;
    idle();                                   lit("post_rst", 5'h00, 5'h00);
    check("post_rst.cnt", 32'(stall_cnt_o), 0);
    check("post_rst.timeout", 32'(timeout_o), 0);

    // Counter saturation
    for (int i = 0; i < CMAX + 7; i++) drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    check("sat.cnt", 32'(stall_cnt_o), CMAX);
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    check("sat_hold.cnt", 32'(stall_cnt_o), CMAX);

    @(posedge clk_i); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
